bip_control: RTL and testbench
==============================

Name: bip_control

Overview:
- Control unit of the BIP-I processor; the instruction-side counterpart of the datapath.
- Owns the program counter and fetches 16-bit instructions from program memory.
- Decodes each opcode into the datapath controls (selA, selB, wrACC, opcode, operand) and the data-memory strobes.
- Sequences execution from start to HLT. Single-cycle execution: one instruction per RUN cycle.

Parameters:
- PC_LENGTH, 11, program-counter / program-memory address width
- INSTR_LENGTH, 16, instruction width: opcode[15:11], operand[10:0]
- OPCODE_LENGTH, 5, opcode width
- OPERANDO_LENGTH, 11, operand width
- CYCLE_CNT_LENGTH, 32, execution cycle counter width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous reset, active-low
- i_start  in  1  one-cycle pulse; begins execution from PC 0
- i_instruction  in  INSTR_LENGTH  program-memory read data for o_pc (asynchronous read)
- o_pc  out  PC_LENGTH  program-memory address
- o_selA  out  2  datapath muxA select: 00 data mem, 01 sign-extended immediate, 10 ALU
- o_selB  out  1  datapath muxB select: 0 data mem, 1 immediate
- o_wrACC  out  1  accumulator write enable
- o_opcode  out  OPCODE_LENGTH  opcode to datapath ALU
- o_operando  out  OPERANDO_LENGTH  operand / data-memory address
- o_wrRAM  out  1  data-memory write strobe (data = ACC)
- o_rdRAM  out  1  data-memory read strobe
- o_done  out  1  high while HALTED
- o_illegal  out  1  sticky: undefined opcode executed
- o_cycle_count  out  CYCLE_CNT_LENGTH  RUN cycles executed since the last start

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE, PC=0, o_cycle_count=0, o_illegal=0, o_done=0. Reset overrides all other inputs, including mid-RUN.
- States:
  - IDLE: all strobes (wrACC/wrRAM/rdRAM) 0; PC held at 0. i_start -> RUN.
  - RUN: one instruction per cycle. Controls are decoded combinationally from i_instruction at the current o_pc. The datapath captures ACC at the same posedge. PC <= PC+1 every RUN cycle except HLT.
  - HALTED: strobes 0; PC frozen at the HLT address; o_done=1. i_start -> RUN with PC<=0, o_cycle_count<=0, o_illegal<=0.
- i_start in RUN is ignored.
- First RUN cycle executes the instruction at address 0; latency from i_start to first wrACC is 1 cycle.
- Decode (RUN only; outside RUN all strobes 0, selA/selB don't-care but driven 0). o_opcode = i_instruction[15:11] and o_operando = i_instruction[10:0] in every state.
  - HLT 00000: no strobes; next state HALTED.
  - STO 00001: wrRAM=1.
  - LD 00010: rdRAM=1, selA=00, wrACC=1.
  - LDI 00011: selA=01, wrACC=1.
  - ADD 00100 / SUB 00110: rdRAM=1, selB=0, selA=10, wrACC=1.
  - ADDI 00101 / SUBI 00111: selB=1, selA=10, wrACC=1.
  - 01000–11111: treated as NOP; no strobes, PC increments, o_illegal set (sticky until reset or restart).
- PC wrap: 2^PC_LENGTH−1 + 1 -> 0, no flag.
- o_cycle_count increments on every RUN cycle, including the HLT cycle. It saturates at all-ones and holds in IDLE/HALTED.
- o_done goes high the cycle after HLT is decoded.

Decomposition:
- Shared package bip_pkg:
  - opcode constants (OP_HLT … OP_SUBI)
  - selA encodings (SELA_MEM, SELA_IMM, SELA_ALU)
  - selB encodings
  - state encodings (ST_IDLE, ST_RUN, ST_HALTED)
  - field bit positions
- The datapath imports the same package.
- One sub-module: bip_instr_decoder. Purely combinational: opcode + run-enable -> selA, selB, wrACC, wrRAM, rdRAM, is_halt, is_illegal.
- PC, FSM and counter stay in bip_control.

Test Plan:
- Reset then idle 10 cycles, no start -> o_pc=0, all strobes 0, o_done=0, o_cycle_count=0.
- Program {LDI 5; ADDI −3 (0x7FD); STO 0x010; HLT}, pulse i_start:
  - cycle 1: wrACC=1, selA=01
  - cycle 2: selA=10, selB=1
  - cycle 3: wrRAM=1, o_operando=0x010
  - o_done high at cycle 5, o_pc stays 3, o_cycle_count=4
- Program {LD 0x004; SUB 0x005; HLT}:
  - LD: rdRAM=1, selA=00
  - SUB: rdRAM=1, selB=0, selA=10, o_opcode=00110
  - o_done after 3 RUN cycles
- Opcode 01010 at address 1 followed by HLT -> no strobes on that cycle, PC advances to 2, o_illegal=1 and remains 1 after halt. Restart clears it.
- i_reset=0 asserted during RUN at PC=7 -> next cycle IDLE, PC=0, strobes 0. i_start pulse during RUN -> ignored, PC continues incrementing.
- Memory of NOP-illegal filler without HLT -> PC wraps 0x7FF->0x000. Pulse i_start in HALTED -> PC=0 and o_cycle_count=0 on the next cycle.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP-I definitions: opcodes, mux encodings, control states and instruction fields.
package bip_pkg;

  localparam int unsigned OPCODE_W    = 5;
  localparam int unsigned OPCODE_MSB  = 15;
  localparam int unsigned OPCODE_LSB  = 11;
  localparam int unsigned OPERAND_MSB = 10;
  localparam int unsigned OPERAND_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder: datapath selects and memory strobes, all forced low outside RUN.
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_run,
  output logic [1:0]          o_selA,
  output logic                o_selB,
  output logic                o_wrACC,
  output logic                o_wrRAM,
  output logic                o_rdRAM,
  output logic                o_is_halt,
  output logic                o_is_illegal
);

  always_comb begin
    o_selA       = SELA_MEM;
    o_selB       = SELB_MEM;
    o_wrACC      = 1'b0;
    o_wrRAM      = 1'b0;
    o_rdRAM      = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    if (i_run) begin
      case (i_opcode)
        OP_HLT: o_is_halt = 1'b1;
        OP_STO: o_wrRAM = 1'b1;
        OP_LD: begin
          o_rdRAM = 1'b1;
          o_selA  = SELA_MEM;
          o_wrACC = 1'b1;
        end
        OP_LDI: begin
          o_selA  = SELA_IMM;
          o_wrACC = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          o_rdRAM = 1'b1;
          o_selB  = SELB_MEM;
          o_selA  = SELA_ALU;
          o_wrACC = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          o_selB  = SELB_IMM;
          o_selA  = SELA_ALU;
          o_wrACC = 1'b1;
        end
        // Undefined opcodes execute as NOP and are only flagged.
        default: o_is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP-I control unit: program counter, IDLE/RUN/HALTED sequencing and the RUN cycle counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned PC_LENGTH        = 11,
  parameter int unsigned INSTR_LENGTH     = 16,
  parameter int unsigned OPCODE_LENGTH    = 5,
  parameter int unsigned OPERANDO_LENGTH  = 11,
  parameter int unsigned CYCLE_CNT_LENGTH = 32
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [INSTR_LENGTH-1:0]     i_instruction,
  output logic [PC_LENGTH-1:0]        o_pc,
  output logic [1:0]                  o_selA,
  output logic                        o_selB,
  output logic                        o_wrACC,
  output logic [OPCODE_LENGTH-1:0]    o_opcode,
  output logic [OPERANDO_LENGTH-1:0]  o_operando,
  output logic                        o_wrRAM,
  output logic                        o_rdRAM,
  output logic                        o_done,
  output logic                        o_illegal,
  output logic [CYCLE_CNT_LENGTH-1:0] o_cycle_count
);

  state_t                      r_state;
  logic [PC_LENGTH-1:0]        r_pc;
  logic [CYCLE_CNT_LENGTH-1:0] r_cycle_count;
  logic                        r_illegal;
  logic                        r_done;

  logic w_run;
  logic w_is_halt;
  logic w_is_illegal;

  assign w_run      = (r_state == ST_RUN);
  assign o_opcode   = i_instruction[INSTR_LENGTH-1 -: OPCODE_LENGTH];
  assign o_operando = i_instruction[OPERANDO_LENGTH-1:0];

  bip_instr_decoder u_decoder (
    .i_opcode     (o_opcode),
    .i_run        (w_run),
    .o_selA       (o_selA),
    .o_selB       (o_selB),
    .o_wrACC      (o_wrACC),
    .o_wrRAM      (o_wrRAM),
    .o_rdRAM      (o_rdRAM),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_cycle_count <= '0;
      r_illegal     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Saturate rather than wrap so long runs never read as short ones.
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
          if (w_is_illegal) r_illegal <= 1'b1;
          if (w_is_halt) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        ST_HALTED: begin
          if (i_start) begin
            r_state       <= ST_RUN;
            r_pc          <= '0;
            r_cycle_count <= '0;
            r_illegal     <= 1'b0;
            r_done        <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_cycle_count = r_cycle_count;
  assign o_illegal     = r_illegal;
  assign o_done        = r_done;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed program scenarios plus random programs vs a model.
module tb_bip_control;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic [4:0]  opcode;
  logic [10:0] operando;
  logic        wr_ram;
  logic        rd_ram;
  logic        done;
  logic        illegal;
  logic [31:0] cycle_count;

  logic [15:0] mem [0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int      m_mode = MIdle;
  int      m_pc   = 0;
  longint  m_cnt  = 0;
  bit      m_ill  = 1'b0;

  assign instr = mem[pc];

  bip_control dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_instruction (instr),
    .o_pc          (pc),
    .o_selA        (sel_a),
    .o_selB        (sel_b),
    .o_wrACC       (wr_acc),
    .o_opcode      (opcode),
    .o_operando    (operando),
    .o_wrRAM       (wr_ram),
    .o_rdRAM       (rd_ram),
    .o_done        (done),
    .o_illegal     (illegal),
    .o_cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input int op, input int arg);
    logic [4:0]  o5;
    logic [10:0] a11;
    o5  = op[4:0];
    a11 = arg[10:0];
    return {o5, a11};
  endfunction

  // Expected controls {selA, selB, wrACC, wrRAM, rdRAM} from the instruction-set table.
  function automatic logic [5:0] exp_ctrl(input int op, input bit run);
    if (!run) return 6'b0;
    case (op)
      1:       return 6'b00_0_010;
      2:       return 6'b00_0_101;
      3:       return 6'b01_0_100;
      4, 6:    return 6'b10_0_101;
      5, 7:    return 6'b10_1_100;
      default: return 6'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] w;
    int op;
    w  = mem[m_pc];
    op = int'(w[15:11]);
    check("pc", 64'(pc), 64'(m_pc));
    check("ctrl", 64'({sel_a, sel_b, wr_acc, wr_ram, rd_ram}), 64'(exp_ctrl(op, m_mode == MRun)));
    check("opcode", 64'(opcode), 64'(w[15:11]));
    check("operando", 64'(operando), 64'(w[10:0]));
    check("done", 64'(done), 64'(m_mode == MHalt));
    check("illegal", 64'(illegal), 64'(m_ill));
    check("cycle_count", 64'(cycle_count), 64'(m_cnt));
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int     n_mode;
    int     n_pc;
    longint n_cnt;
    bit     n_ill;
    int     op;
    n_mode = m_mode;
    n_pc   = m_pc;
    n_cnt  = m_cnt;
    n_ill  = m_ill;
    op     = int'(mem[m_pc] >> 11);
    if (!rst_n) begin
      n_mode = MIdle;
      n_pc   = 0;
      n_cnt  = 0;
      n_ill  = 1'b0;
    end else if (m_mode == MIdle) begin
      if (start) n_mode = MRun;
    end else if (m_mode == MRun) begin
      if (m_cnt < 64'hFFFF_FFFF) n_cnt = m_cnt + 1;
      if (op >= 8) n_ill = 1'b1;
      if (op == 0) n_mode = MHalt;
      else n_pc = (m_pc + 1) % 2048;
    end else if (start) begin
      n_mode = MRun;
      n_pc   = 0;
      n_cnt  = 0;
      n_ill  = 1'b0;
    end
    @(posedge clk);
    #1;
    m_mode = n_mode;
    m_pc   = n_pc;
    m_cnt  = n_cnt;
    m_ill  = n_ill;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(mk(0, 0));

    // Reset, then idle without start
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all();
    end
    check("idle_pc", 64'(pc), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    // LDI 5; ADDI -3; STO 0x010; HLT
    mem[0] = mk(3, 5);
    mem[1] = mk(5, 11'h7FD);
    mem[2] = mk(1, 11'h010);
    mem[3] = mk(0, 0);
    pulse_start();
    check("p1_c1_wracc", 64'(wr_acc), 64'd1);
    check("p1_c1_sela", 64'(sel_a), 64'b01);
    tick();
    check_all();
    check("p1_c2_ctrl", 64'({sel_a, sel_b}), 64'b101);
    tick();
    check_all();
    check("p1_c3_wrram", 64'({wr_ram, operando}), 64'({1'b1, 11'h010}));
    tick();
    check_all();
    tick();
    check_all();
    check("p1_done", 64'({done, pc, cycle_count}), 64'({1'b1, 11'd3, 32'd4}));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all();
    end
    check("p1_pc_frozen", 64'(pc), 64'd3);

    // LD 0x004; SUB 0x005; HLT
    fill(mk(0, 0));
    mem[0] = mk(2, 11'h004);
    mem[1] = mk(6, 11'h005);
    pulse_start();
    check("p2_ld", 64'({rd_ram, sel_a, wr_acc}), 64'({1'b1, 2'b00, 1'b1}));
    tick();
    check_all();
    check("p2_sub", 64'({rd_ram, sel_b, sel_a, opcode}), 64'({1'b1, 1'b0, 2'b10, 5'b00110}));
    tick();
    check_all();
    tick();
    check_all();
    check("p2_done", 64'({done, cycle_count}), 64'({1'b1, 32'd3}));

    // Illegal opcode at address 1
    fill(mk(0, 0));
    mem[0] = mk(3, 1);
    mem[1] = mk(5'b01010, 11'h3AB);
    pulse_start();
    tick();
    check_all();
    check("ill_nostrobe", 64'({wr_acc, wr_ram, rd_ram, pc}), 64'({3'b000, 11'd1}));
    tick();
    check_all();
    check("ill_set", 64'({illegal, pc}), 64'({1'b1, 11'd2}));
    tick();
    check_all();
    check("ill_sticky", 64'({illegal, done}), 64'b11);
    pulse_start();
    check("ill_cleared", 64'(illegal), 64'd0);

    // Reset mid-RUN at PC 7, then ignored start during RUN
    fill(mk(5, 1));
    mem[20] = mk(0, 0);
    tick();
    check_all();
    for (int i = 0; i < 40 && m_pc != 7; i++) begin
      tick();
      check_all();
    end
    check("rst_at_pc7", 64'(pc), 64'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all();
    check("rst_idle", 64'({pc, wr_acc, wr_ram, rd_ram, cycle_count}), 64'd0);
    pulse_start();
    tick();
    check_all();
    pulse_start();
    check("start_ignored_pc", 64'(pc), 64'd2);
    tick();
    check_all();
    check("start_ignored_pc2", 64'(pc), 64'd3);

    // Illegal filler, PC wraps, later halts
    for (int i = 0; i < 30; i++) begin
      tick();
      check_all();
    end
    fill(16'h4000);
    pulse_start();
    for (int i = 0; i < 2100 && m_pc != 2047; i++) begin
      tick();
      check_all();
    end
    check("wrap_at_7ff", 64'(pc), 64'h7FF);
    tick();
    check_all();
    check("wrap_to_0", 64'({pc, done}), 64'd0);
    mem[3] = mk(0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all();
    end
    check("wrap_halted", 64'({done, pc}), 64'({1'b1, 11'd3}));
    pulse_start();
    check("restart_clears", 64'({pc, cycle_count}), 64'd0);

    // Random programs
    for (int p = 0; p < 30; p++) begin
      fill(mk(0, 0));
      for (int a = 0; a < 64; a++) begin
        int r;
        int op;
        r  = int'($urandom_range(0, 15));
        op = (r < 1) ? 0 : (r < 13) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 31));
        mem[a] = mk(op, int'($urandom_range(0, 2047)));
      end
      for (int c = 0; c < 90; c++) begin
        start = ($urandom_range(0, 7) == 0) || (m_mode != MRun && $urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 59) != 0);
        tick();
        check_all();
      end
      start = 1'b0;
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
